// File: rtl/motor_drive_sequencer.sv
// Arbitrates manual/auto drive requests, ramps the PWM compare value, sequences brake/dead-time on reversal.
// Latency: request -> grant/state 1 cycle; duty moves only on ramp ticks; overcurrent trip after OC_FILTER samples.
// No backpressure: requests are levels sampled every cycle, outputs are registered and always valid.
module motor_drive_sequencer #(
    parameter int PERIOD      = 250000,
    parameter int RAMP_STEP   = 625,
    parameter int RAMP_DIV    = 100000,
    parameter int DEAD_CYCLES = 5000000,
    parameter int OC_FILTER   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        man_req,
    input  logic        man_dir,
    input  logic [18:0] man_duty,
    input  logic        auto_req,
    input  logic        auto_dir,
    input  logic [18:0] auto_duty,
    input  logic        oc_a,
    input  logic        oc_b,
    input  logic        oc_clear,
    output logic [18:0] pulse_width,
    output logic [1:0]  dir_a,
    output logic [1:0]  dir_b,
    output logic [1:0]  grant,
    output logic        fault,
    output logic [2:0]  state
);
    localparam int DIV_W  = $clog2(RAMP_DIV + 1);
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int OC_W   = $clog2(OC_FILTER + 1);

    localparam logic [19:0]       PERIOD_W  = 20'(PERIOD);
    localparam logic [19:0]       STEP_W    = 20'(RAMP_STEP);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [OC_W-1:0]   OC_LAST   = OC_W'(OC_FILTER - 1);
    localparam logic [OC_W-1:0]   OC_MAX    = OC_W'(OC_FILTER);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_BRAKE = 3'd2,
        ST_DEAD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                cur_dir_q, cur_dir_d;
    logic [18:0]         duty_q, duty_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic [DIV_W-1:0]    div_q;
    logic [OC_W-1:0]     oc_q, oc_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          pin_a_q, pin_a_d;
    logic [1:0]          pin_b_q, pin_b_d;

    logic                gnt_vld, gnt_dir;
    logic [19:0]         target;
    logic                tick, oc_any, trip;

    // One step toward the target, never overshooting; done in 20 bits so nothing wraps.
    function automatic logic [18:0] ramp(input logic [18:0] cur, input logic [19:0] tgt);
        logic [19:0] c;
        logic [19:0] r;
        c = {1'b0, cur};
        if (c < tgt)
            r = ((tgt - c) > STEP_W) ? c + STEP_W : tgt;
        else if (c > tgt)
            r = ((c - tgt) > STEP_W) ? c - STEP_W : tgt;
        else
            r = c;
        return 19'(r);
    endfunction

    assign tick   = (div_q == DIV_LAST);
    assign oc_any = oc_a | oc_b;
    // Counter saturates at OC_FILTER, so a sustained overcurrent keeps re-asserting the trip.
    assign trip   = oc_any && (oc_q >= OC_LAST);

    // Manual strictly beats auto; granted duty clamped to the carrier period.
    always_comb begin
        gnt_vld = man_req | auto_req;
        gnt_dir = man_req ? man_dir : auto_dir;
        grant_d = man_req ? 2'b01 : (auto_req ? 2'b10 : 2'b00);
        target  = '0;
        if (gnt_vld) begin
            target = {1'b0, (man_req ? man_duty : auto_duty)};
            if (target > PERIOD_W)
                target = PERIOD_W;
        end
        oc_d = '0;
        if (oc_any)
            oc_d = (oc_q == OC_MAX) ? oc_q : oc_q + 1'b1;
    end

    // Next state, duty, direction and dead-time counter; overcurrent trip overrides everything.
    always_comb begin
        state_d   = state_q;
        cur_dir_d = cur_dir_q;
        duty_d    = duty_q;
        dead_d    = '0;
        case (state_q)
            ST_IDLE: begin
                duty_d = '0;
                if (gnt_vld)
                    state_d = (gnt_dir == cur_dir_q) ? ST_RUN : ST_DEAD;
            end
            ST_RUN: begin
                if (tick)
                    duty_d = ramp(duty_q, target);
                if (gnt_vld && (gnt_dir != cur_dir_q))
                    state_d = ST_BRAKE;
                else if (!gnt_vld && (duty_q == '0))
                    state_d = ST_IDLE;
            end
            ST_BRAKE: begin
                if (tick)
                    duty_d = ramp(duty_q, 20'd0);
                if (duty_q == '0)
                    state_d = ST_DEAD;
            end
            ST_DEAD: begin
                duty_d = '0;
                if (dead_q == DEAD_LAST) begin
                    if (gnt_vld) begin
                        cur_dir_d = gnt_dir;
                        state_d   = ST_RUN;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    dead_d = dead_q + 1'b1;
                end
            end
            ST_FAULT: begin
                duty_d = '0;
                if (oc_clear && !oc_any)
                    state_d = ST_IDLE;
            end
            default: begin
                duty_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
        if (trip) begin
            state_d = ST_FAULT;
            duty_d  = '0;
            dead_d  = '0;
        end
    end

    // Bridge pins follow the direction only in states that drive or brake; otherwise coast.
    always_comb begin
        pin_a_d = 2'b00;
        pin_b_d = 2'b00;
        if (state_d == ST_IDLE || state_d == ST_RUN || state_d == ST_BRAKE) begin
            pin_a_d = cur_dir_d ? 2'b10 : 2'b01;
            pin_b_d = cur_dir_d ? 2'b01 : 2'b10;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cur_dir_q <= 1'b1;
            duty_q    <= '0;
            dead_q    <= '0;
            div_q     <= '0;
            oc_q      <= '0;
            grant_q   <= 2'b00;
            pin_a_q   <= 2'b00;
            pin_b_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            cur_dir_q <= cur_dir_d;
            duty_q    <= duty_d;
            dead_q    <= dead_d;
            div_q     <= tick ? '0 : div_q + 1'b1;
            oc_q      <= oc_d;
            grant_q   <= grant_d;
            pin_a_q   <= pin_a_d;
            pin_b_q   <= pin_b_d;
        end
    end

    assign pulse_width = duty_q;
    assign dir_a       = pin_a_q;
    assign dir_b       = pin_b_q;
    assign grant       = grant_q;
    assign fault       = (state_q == ST_FAULT);
    assign state       = state_q;
endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Directed bench for motor_drive_sequencer with small parameters.
// Checks are taken 1 time unit after the rising edge.
// Waits on DUT events are bounded and count as failed checks if they expire.
module tb_motor_drive_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        man_req = 1'b0, man_dir = 1'b0;
    logic [18:0] man_duty = '0;
    logic        auto_req = 1'b0, auto_dir = 1'b0;
    logic [18:0] auto_duty = '0;
    logic        oc_a = 1'b0, oc_b = 1'b0, oc_clear = 1'b0;
    logic [18:0] pulse_width;
    logic [1:0]  dir_a, dir_b, grant;
    logic        fault;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    motor_drive_sequencer #(
        .PERIOD(1000), .RAMP_STEP(100), .RAMP_DIV(10), .DEAD_CYCLES(50), .OC_FILTER(8)
    ) dut (
        .clk(clk), .reset(reset),
        .man_req(man_req), .man_dir(man_dir), .man_duty(man_duty),
        .auto_req(auto_req), .auto_dir(auto_dir), .auto_duty(auto_duty),
        .oc_a(oc_a), .oc_b(oc_b), .oc_clear(oc_clear),
        .pulse_width(pulse_width), .dir_a(dir_a), .dir_b(dir_b),
        .grant(grant), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pw(input string tag, input logic [18:0] v, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (pulse_width == v) break;
            step(1);
        end
        chk(tag, 32'(pulse_width), 32'(v));
    endtask

    task automatic wait_state(input string tag, input logic [2:0] v, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (state == v) break;
            step(1);
        end
        chk(tag, 32'(state), 32'(v));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pw"},    32'(pulse_width), 0);
        chk({tag, "_dira"},  32'(dir_a), 0);
        chk({tag, "_dirb"},  32'(dir_b), 0);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_state"}, 32'(state), 0);
    endtask

    initial begin
        // Reset
        step(3);
        chk_reset_vals("rst");
        reset = 1'b1;
        step(1);
        chk("idle_state", 32'(state), 0);
        chk("idle_dira_fwd", 32'(dir_a), 32'b10);
        chk("idle_dirb_fwd", 32'(dir_b), 32'b01);

        // Auto forward to full duty
        auto_req = 1'b1; auto_dir = 1'b1; auto_duty = 19'd1000;
        step(1);
        chk("auto_grant", 32'(grant), 32'b10);
        chk("auto_run", 32'(state), 1);
        chk("auto_dira", 32'(dir_a), 32'b10);
        chk("auto_dirb", 32'(dir_b), 32'b01);
        wait_pw("ramp_first", 19'd100, 12);
        step(9);
        chk("ramp_hold9", 32'(pulse_width), 100);
        step(1);
        chk("ramp_second", 32'(pulse_width), 200);
        step(80);
        chk("ramp_full", 32'(pulse_width), 1000);
        step(30);
        chk("ramp_hold", 32'(pulse_width), 1000);

        // Manual takes over at lower duty
        man_req = 1'b1; man_dir = 1'b1; man_duty = 19'd300;
        step(1);
        chk("man_grant", 32'(grant), 32'b01);
        wait_pw("man_down", 19'd300, 75);
        step(25);
        chk("man_hold", 32'(pulse_width), 300);

        // Up to 500, then reverse
        man_duty = 19'd500;
        wait_pw("man_500", 19'd500, 25);
        step(20);
        man_dir = 1'b0;
        step(1);
        chk("brake_state", 32'(state), 2);
        chk("brake_dira", 32'(dir_a), 32'b10);
        wait_pw("brake_zero", 19'd0, 55);
        step(1);
        chk("dead_state", 32'(state), 3);
        chk("dead_dira", 32'(dir_a), 0);
        chk("dead_dirb", 32'(dir_b), 0);
        step(48);
        chk("dead_mid", 32'(state), 3);
        step(1);
        chk("dead_last", 32'(state), 3);
        step(1);
        chk("rev_run", 32'(state), 1);
        chk("rev_dira", 32'(dir_a), 32'b01);
        chk("rev_dirb", 32'(dir_b), 32'b10);
        wait_pw("rev_ramp", 19'd100, 12);

        // Duty above PERIOD saturates
        man_duty = 19'd1500;
        wait_pw("sat_reach", 19'd1000, 110);
        step(30);
        chk("sat_hold", 32'(pulse_width), 1000);

        // Overcurrent filter: 7 samples no trip, 8 trips
        oc_b = 1'b1;
        step(7);
        oc_b = 1'b0;
        step(1);
        chk("oc7_fault", 32'(fault), 0);
        chk("oc7_state", 32'(state), 1);
        step(3);
        oc_b = 1'b1;
        step(7);
        chk("oc8_pre", 32'(fault), 0);
        step(1);
        chk("oc8_fault", 32'(fault), 1);
        chk("oc8_pw", 32'(pulse_width), 0);
        chk("oc8_dira", 32'(dir_a), 0);
        chk("oc8_dirb", 32'(dir_b), 0);
        chk("oc8_state", 32'(state), 4);
        oc_clear = 1'b1;
        step(3);
        chk("clr_blocked", 32'(state), 4);
        chk("clr_blocked_flt", 32'(fault), 1);
        oc_b = 1'b0;
        step(1);
        chk("clr_idle", 32'(state), 0);
        chk("clr_fault", 32'(fault), 0);
        oc_clear = 1'b0;
        wait_pw("post_fault_ramp", 19'd100, 15);

        // Reset in the middle of DEAD
        man_dir = 1'b1;
        wait_state("to_dead", 3'd3, 60);
        step(5);
        reset = 1'b0;
        step(1);
        chk_reset_vals("rst_dead");
        reset = 1'b1;
        man_req = 1'b0; auto_req = 1'b0;
        step(1);
        chk("rst_idle_dira", 32'(dir_a), 32'b10);

        // From IDLE a reverse request goes straight to DEAD
        man_req = 1'b1; man_dir = 1'b0; man_duty = 19'd200;
        step(1);
        chk("idle_rev_dead", 32'(state), 3);
        chk("idle_rev_dira", 32'(dir_a), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/motor_drive_sequencer.md
# motor_drive_sequencer

Sequences the shared two-motor L298 drive: arbitrates speed/direction requests between the manual switch source and the autonomous (ultrasonic distance) source, ramps the PWM compare value toward the granted target, and inserts a brake-and-dead-time sequence on every direction reversal. It latches a filtered overcurrent fault that forces the bridge to coast. It sits between the request sources and the PWM carrier counter / bridge pins. Its `pulse_width` drives the existing 400 Hz PWM comparator directly.

## Interface
- PERIOD, 250000, PWM carrier period in clk cycles; upper clamp for duty
- RAMP_STEP, 625, duty change per ramp tick
- RAMP_DIV, 100000, clk cycles per ramp tick
- DEAD_CYCLES, 5000000, coast time on reversal (50 ms at 100 MHz)
- OC_FILTER, 1000, consecutive overcurrent cycles required to trip
- clk  in  1  100 MHz system clock
- reset  in  1  synchronous, active-low
- man_req / man_dir / man_duty  in  1/1/19  manual request; dir 1=forward, 0=reverse
- auto_req / auto_dir / auto_duty  in  1/1/19  autonomous request, same encoding
- oc_a, oc_b  in  1  overcurrent sense, active high, pre-synchronised
- oc_clear  in  1  fault clear request, level
- pulse_width  out  19  PWM compare value to carrier comparator
- dir_a  out  2  {IN1,IN2} motor A: fwd 2'b10, rev 2'b01, coast 2'b00
- dir_b  out  2  {IN3,IN4} motor B (mirrored): fwd 2'b01, rev 2'b10, coast 2'b00
- grant  out  2  2'b01 manual, 2'b10 auto, 2'b00 none
- fault  out  1  overcurrent latched
- state  out  3  FSM state code for seven-segment display

## Operation
- Reset (reset=0 at a clk edge): pulse_width=0, dir_a=dir_b=00, grant=00, fault=0, state=IDLE(0), cur_dir=forward, all counters 0.
- Arbitration: manual strictly over auto. Target = granted duty clamped to PERIOD; with no grant, target = 0.
- Ramp: a tick fires every RAMP_DIV cycles (free-running divider). Per tick: duty<target → min(duty+RAMP_STEP, target); duty>target → max(duty−RAMP_STEP, target). Compute in 20 bits; no wrap.
- States, encoded IDLE=0, RUN=1, BRAKE=2, DEAD=3, FAULT=4:
  - IDLE: duty 0; dir pins show cur_dir.
    - Grant with dir==cur_dir → RUN.
    - Grant with dir≠cur_dir → DEAD.
  - RUN: ramp toward target; dir pins show cur_dir.
    - Granted dir≠cur_dir → BRAKE.
    - No grant and duty==0 → IDLE.
  - BRAKE: target forced 0; pins keep cur_dir. Duty reaches 0 → DEAD.
  - DEAD: duty 0, pins 00. Counter runs 0..DEAD_CYCLES−1, then:
    - Grant present → cur_dir ← granted dir at exit, → RUN.
    - No grant → IDLE with cur_dir unchanged.
    - Request changes during DEAD do not restart the counter.
  - FAULT: pulse_width=0 immediately, pins 00, fault=1. Exits to IDLE only when oc_clear=1 and oc_a=oc_b=0 in the same cycle; fault clears on that exit.
- Overcurrent filter: the counter increments while (oc_a|oc_b), clears on any low cycle. Reaching OC_FILTER enters FAULT from any state. FAULT has priority over all other transitions.

## Timing
- All outputs registered; request → grant/state change latency 1 cycle.
- Ramp-driven duty changes occur only on ramp-tick cycles. A full 0→PERIOD ramp takes ceil(PERIOD/RAMP_STEP) ticks.
- Overcurrent asserted continuously → fault=1, pulse_width=0, pins 00 on cycle OC_FILTER+1 after first high sample.
- FAULT exit → IDLE at the next edge; duty restarts ramp from 0.
- Reset mid-ramp or mid-DEAD: all state abandoned, outputs to reset values next edge.
- Simultaneous fault trip and oc_clear: trip wins.

## Test plan
Test parameters: PERIOD=1000, RAMP_STEP=100, RAMP_DIV=10, DEAD_CYCLES=50, OC_FILTER=8.
- auto_req=1, dir=1, duty=1000 → grant=10, dir_a=10, dir_b=01; pulse_width +100 every 10 cycles, holds 1000 after 10 ticks.
- RUN at 1000 with auto, then man_req=1, dir=1, duty=300 → grant=01 next cycle; duty steps down to 300 and holds.
- RUN at 500 forward, request flips to dir=0 → BRAKE down to 0 in 5 ticks, pins 00 for exactly 50 cycles, then dir_a=01, dir_b=10, ramp up.
- man_duty=1500 → pulse_width saturates at 1000.
- oc_b high 7 cycles then low → no fault. High 8 cycles → fault=1, pulse_width=0, pins 00. oc_clear with oc_b still high → stays FAULT. oc_b low + oc_clear → IDLE.
- reset=0 during DEAD → all outputs to reset values next edge, state=0.
